su_prod_accum: RTL and testbench
================================

# su_prod_accum

Streaming accumulation stage that sits directly downstream of the 4x4 signed×unsigned multiplier. It consumes the multiplier's 8-bit two's-complement products over a valid/ready handshake and sums up to LEN of them into a signed accumulator. It presents each finished dot-product with its beat count and a sticky saturation flag on a registered valid/ready output.

## Interface
- LEN, 16: products per vector; range 2..255.
- ACC_W, 16: accumulator and result width in bits; must be at least 8.
- SAT, 1: 1 = clamp to signed ACC_W bounds; 0 = wrap modulo 2^ACC_W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  a product beat is presented.
- in_ready  out  1  the block accepts the beat this cycle.
- in_prod  in  8  signed product, two's complement; multiplier range is -120..105.
- in_last  in  1  closes the vector early on this beat.
- out_valid  out  1  result registers hold a finished vector.
- out_ready  in  1  the consumer accepts the result.
- out_sum  out  ACC_W  signed sum of the vector.
- out_count  out  8  number of beats in the vector, 1..LEN.
- out_sat  out  1  one or more additions in this vector were clamped (SAT=1) or overflowed (SAT=0).

## Operation
- State machine with two states:
  - ACC: accumulating.
  - HOLD: result waiting for the consumer.
- Internal registers: acc (ACC_W), cnt (8), sat_flag.
- Beat accept: in_valid && in_ready.
- Addition: in_prod is sign-extended to ACC_W+1 bits. The next value is nxt = acc + sext(in_prod).
- Saturation when SAT=1:
  - If nxt > 2^(ACC_W-1)-1, the result is 2^(ACC_W-1)-1 and sat_flag is set.
  - If nxt < -2^(ACC_W-1), the result is -2^(ACC_W-1) and sat_flag is set.
- Overflow when SAT=0: the result keeps the low ACC_W bits, and sat_flag is set on signed overflow.
- A beat closes the vector when cnt+1 == LEN or in_last=1.
- On a closing beat:
  - out_sum takes the new acc value.
  - out_count takes cnt+1.
  - out_sat takes the updated sat_flag.
  - acc, cnt and sat_flag clear to 0, and the next state is HOLD.
- On a non-closing beat: acc, cnt and sat_flag update and the state stays ACC.
- in_ready = (state==ACC) || (state==HOLD && out_ready).
  - A beat accepted while in HOLD with out_ready=1 starts the next vector from zero in the same cycle the result leaves.
  - If that beat is itself closing (in_last=1), it reloads the output registers and the state stays HOLD.
- HOLD with out_ready=1 and no accepted beat: the next state is ACC and out_valid falls.
- clear=1:
  - acc, cnt and sat_flag go to 0; out_valid goes to 0; the state goes to ACC.
  - Any beat presented that cycle is dropped.
  - in_ready reads 0 during the clear cycle.
- in_prod, in_last and out_* are don't-care when their valid signal is low. Output registers hold their value until they are reloaded.

## Timing
- Reset (rst_n=0), applied asynchronously:
  - state=ACC.
  - acc=0, cnt=0, sat_flag=0.
  - out_valid=0, out_sum=0, out_count=0, out_sat=0.
  - in_ready=0 while rst_n is low, and 1 in the first cycle after release.
- Latency: a result is visible with out_valid=1 in the cycle after its closing beat is accepted.
- Throughput: back-to-back vectors with no bubble while out_ready is held at 1. A full-length vector costs LEN cycles.
- out_valid, out_sum, out_count and out_sat come straight from registers. in_ready is combinational from state and out_ready only; there is no path from in_valid.
- Handshake rules:
  - While out_valid=1 and out_ready=0, all out_* are stable and in_ready=0.
  - in_valid may drop at any time; no beat is implied.
- Reset asserted mid-vector discards the partial sum immediately. The same applies to a pending result.

## Test plan
- Defaults; 16 beats of in_prod=105 with out_ready=1 -> out_valid pulses 1 cycle after beat 16, out_sum=1680, out_count=16, out_sat=0.
- in_last on the 3rd beat of {-120, 7, 1} -> out_sum=-112 (0xFF90), out_count=3. The next vector starts from 0.
- ACC_W=10, SAT=1; 16 beats of -120 -> out_sum=-512, out_sat=1. With SAT=0 the same stimulus gives out_sum=-1920 mod 1024 = 128, out_sat=1.
- out_ready=0 for 5 cycles after a result -> in_ready=0 and out_* stable. Raising out_ready with in_valid=1 accepts the first beat of the next vector in that same cycle.
- Two 1-beat vectors back-to-back (in_last=1, values 5 then -3, out_ready=1) -> out_valid stays high 2 consecutive cycles with out_sum 5 then -3, out_count=1 each.
- clear, or rst_n low, after 7 beats -> out_valid=0 and nothing is emitted. A following 16-beat vector of +1 gives out_sum=16, out_count=16.

Source files
------------

// File: rtl/su_prod_accum.sv
// su_prod_accum
// Streaming accumulation stage for signed 8-bit products. It sums up to LEN
// beats, or fewer when in_last closes the vector early, into a signed ACC_W-bit
// accumulator. It then presents the finished sum, the beat count and a sticky
// saturation/overflow flag on a registered valid/ready output.
//
// Parameters:
//   LEN   : products per vector (2..255)
//   ACC_W : accumulator / result width (>= 8)
//   SAT   : 1 = clamp to signed ACC_W bounds, 0 = wrap modulo 2^ACC_W
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous flush, drops any presented beat
//   in_valid/in_ready : product beat handshake
//   in_prod, in_last  : signed product, early end-of-vector marker
//   out_valid/out_ready : result handshake
//   out_sum, out_count, out_sat : registered result fields
module su_prod_accum #(
  parameter int LEN   = 16,
  parameter int ACC_W = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_e;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W:0]   nxt;
  logic             ovf;
  logic             accept;
  logic             closing;

  // in_ready does not depend on in_valid. It is forced low while in reset and
  // during a clear cycle, so a presented beat is never reported as accepted.
  assign in_ready = rst_n && !clear && ((state_q == ST_ACC) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    nxt   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){in_prod[7]}}, in_prod};
    // The two top bits of the ACC_W+1 sum disagree exactly when the result
    // falls outside the signed ACC_W range.
    ovf   = nxt[ACC_W] ^ nxt[ACC_W-1];
    acc_d = nxt[ACC_W-1:0];
    if (SAT && ovf) begin
      acc_d = nxt[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    sat_d   = sat_q || ovf;
    cnt_d   = cnt_q + 8'd1;
    closing = (cnt_d == 8'(LEN)) || in_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // A beat taken in HOLD always has out_ready=1, so the held result leaves
      // in the same cycle. acc/cnt/sat are already zero from the previous close.
      if (closing) begin
        out_sum   <= acc_d;
        out_count <= cnt_d;
        out_sat   <= sat_d;
        out_valid <= 1'b1;
        acc_q     <= '0;
        cnt_q     <= '0;
        sat_q     <= 1'b0;
        state_q   <= ST_HOLD;
      end else begin
        acc_q     <= acc_d;
        cnt_q     <= cnt_d;
        sat_q     <= sat_d;
        out_valid <= 1'b0;
        state_q   <= ST_ACC;
      end
    end else if (state_q == ST_HOLD && out_ready) begin
      out_valid <= 1'b0;
      state_q   <= ST_ACC;
    end
  end

endmodule

// File: tb/tb_su_prod_accum.sv
// Directed bench for su_prod_accum. Three instances share the input stimulus:
// the default configuration, plus ACC_W=10 with SAT=1 and with SAT=0.
module tb_su_prod_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       in_last;
  logic       out_ready;

  logic        rdy_a, vld_a, sat_a;
  logic [15:0] sum_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, vld_b, sat_b;
  logic [9:0]  sum_b;
  logic [7:0]  cnt_b;
  logic        rdy_c, vld_c, sat_c;
  logic [9:0]  sum_c;
  logic [7:0]  cnt_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  su_prod_accum u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_a), .in_prod(in_prod), .in_last(in_last),
    .out_valid(vld_a), .out_ready(out_ready),
    .out_sum(sum_a), .out_count(cnt_a), .out_sat(sat_a)
  );

  su_prod_accum #(.LEN(16), .ACC_W(10), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_b), .in_prod(in_prod), .in_last(in_last),
    .out_valid(vld_b), .out_ready(out_ready),
    .out_sum(sum_b), .out_count(cnt_b), .out_sat(sat_b)
  );

  su_prod_accum #(.LEN(16), .ACC_W(10), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_c), .in_prod(in_prod), .in_last(in_last),
    .out_valid(vld_c), .out_ready(out_ready),
    .out_sum(sum_c), .out_count(cnt_c), .out_sat(sat_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and advance to just after the capturing edge.
  task automatic send(input logic [7:0] prod, input logic last);
    in_valid = 1'b1;
    in_prod  = prod;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0;
    in_last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(vld_a), 32'd0);
    chk("rst_sum",   32'(sum_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_sat",   32'(sat_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(rdy_a), 32'd1);

    // Full-length vector of 105: 16*105 = 1680.
    for (int i = 0; i < 15; i++) send(8'd105, 1'b0);
    chk("full_early_valid", 32'(vld_a), 32'd0);
    send(8'd105, 1'b0);
    chk("full_valid", 32'(vld_a), 32'd1);
    chk("full_sum",   32'(sum_a), 32'd1680);
    chk("full_count", 32'(cnt_a), 32'd16);
    chk("full_sat",   32'(sat_a), 32'd0);
    idle_cycle();
    chk("full_pulse", 32'(vld_a), 32'd0);

    // Early close on the third beat: -120+7+1 = -112.
    send(8'h88, 1'b0);
    send(8'd7,  1'b0);
    send(8'd1,  1'b1);
    chk("last_valid", 32'(vld_a), 32'd1);
    chk("last_sum",   32'(sum_a), 32'h0000FF90);
    chk("last_count", 32'(cnt_a), 32'd3);

    // 16 beats of -120, starting straight out of HOLD: -1920 in 16 bits,
    // clamped to -512 or wrapped to 128 in 10 bits.
    for (int i = 0; i < 16; i++) send(8'h88, 1'b0);
    chk("neg_sum16",    32'(sum_a), 32'h0000F880);
    chk("neg_cnt16",    32'(cnt_a), 32'd16);
    chk("neg_sat16",    32'(sat_a), 32'd0);
    chk("clamp_valid",  32'(vld_b), 32'd1);
    chk("clamp_sum",    32'(sum_b), 32'h200);
    chk("clamp_sat",    32'(sat_b), 32'd1);
    chk("wrap_sum",     32'(sum_c), 32'd128);
    chk("wrap_sat",     32'(sat_c), 32'd1);
    chk("wrap_count",   32'(cnt_c), 32'd16);

    // Backpressure: result 3+4 held for 5 cycles while a beat waits.
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_prod   = 8'd9;
    in_last   = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(rdy_a), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(vld_a), 32'd1);
      chk("bp_sum",   32'(sum_a), 32'd7);
      chk("bp_count", 32'(cnt_a), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rdy_a), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(vld_a), 32'd0);
    send(8'd1, 1'b1);
    chk("bp_next_sum",   32'(sum_a), 32'd10);
    chk("bp_next_count", 32'(cnt_a), 32'd2);

    // Two single-beat vectors back to back.
    idle_cycle();
    chk("one_idle", 32'(vld_a), 32'd0);
    send(8'd5, 1'b1);
    chk("one_a_valid", 32'(vld_a), 32'd1);
    chk("one_a_sum",   32'(sum_a), 32'd5);
    chk("one_a_count", 32'(cnt_a), 32'd1);
    send(8'hFD, 1'b1);
    chk("one_b_valid", 32'(vld_a), 32'd1);
    chk("one_b_sum",   32'(sum_a), 32'h0000FFFD);
    chk("one_b_count", 32'(cnt_a), 32'd1);
    idle_cycle();
    chk("one_drop", 32'(vld_a), 32'd0);

    // clear after 7 beats; the beat presented with clear is dropped.
    for (int i = 0; i < 7; i++) send(8'd50, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd1;
    #1;
    chk("clr_ready", 32'(rdy_a), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_valid", 32'(vld_a), 32'd0);
    for (int i = 0; i < 15; i++) send(8'd1, 1'b0);
    chk("clr_no_early", 32'(vld_a), 32'd0);
    send(8'd1, 1'b0);
    chk("clr_valid16", 32'(vld_a), 32'd1);
    chk("clr_sum16",   32'(sum_a), 32'd16);
    chk("clr_cnt16",   32'(cnt_a), 32'd16);

    // Asynchronous reset after 7 beats discards the pending result and sum.
    for (int i = 0; i < 7; i++) send(8'd50, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("arst_valid", 32'(vld_a), 32'd0);
    chk("arst_sum",   32'(sum_a), 32'd0);
    chk("arst_ready", 32'(rdy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) send(8'd1, 1'b0);
    chk("arst_no_early", 32'(vld_a), 32'd0);
    send(8'd1, 1'b0);
    chk("arst_valid16", 32'(vld_a), 32'd1);
    chk("arst_sum16",   32'(sum_a), 32'd16);
    chk("arst_cnt16",   32'(cnt_a), 32'd16);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
